// File: rtl/vid_sched_pkg.sv
// rtl/vid_sched_pkg.sv - shared types and constants for the triple-buffer swap scheduler
package vid_sched_pkg;

  typedef logic [1:0] buf_idx_t;

  // One-hot scheduler states
  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_SWAP = 3'b010;
  localparam logic [2:0] ST_WAIT = 3'b100;

  localparam buf_idx_t RST_WR_IDX  = 2'd0;
  localparam buf_idx_t RST_RDY_IDX = 2'd1;
  localparam buf_idx_t RST_RD_IDX  = 2'd2;

  // The receiver needs a 2-FF synchronizer plus an edge detect
  localparam int SWAP_PW_MIN = 2;

  typedef struct packed {
    logic [7:0]  thsync;
    logic [7:0]  tgdel;
    logic [15:0] tgate;
    logic [15:0] thlen;
  } tim_cfg_t;

endpackage

// File: rtl/swap_pulse_stretch.sv
// rtl/swap_pulse_stretch.sv - holds the swap request high for exactly PW clocks
module swap_pulse_stretch #(
  parameter int PW = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic pulse,
  output logic done
);

  localparam int CW = (PW > 2) ? $clog2(PW) : 1;
  localparam logic [CW-1:0] LOAD = CW'(PW - 1);

  logic [CW-1:0] cnt;

  // Load on start, count down while high, drop the pulse after the last count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      pulse <= 1'b1;
      cnt   <= LOAD;
    end else if (pulse) begin
      if (cnt == '0) begin
        pulse <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign done = pulse && (cnt == '0);

endmodule

// File: rtl/vid_swap_sched.sv
// rtl/vid_swap_sched.sv - triple-buffer swap scheduler with shadowed timing (drop counter under VID_SCHED_STATS_EN)
module vid_swap_sched
  import vid_sched_pkg::*;
#(
  parameter int          SWAP_PW    = 4,
  parameter logic [7:0]  DEF_THSYNC = 8'd4,
  parameter logic [7:0]  DEF_TGDEL  = 8'd2,
  parameter logic [15:0] DEF_TGATE  = 16'd64,
  parameter logic [15:0] DEF_THLEN  = 16'd100
`ifdef VID_SCHED_STATS_EN
  , parameter int        DROP_W     = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wr_done,
  input  logic        disp_done,
  input  logic        cfg_wr,
  input  logic [7:0]  cfg_thsync,
  input  logic [7:0]  cfg_tgdel,
  input  logic [15:0] cfg_tgate,
  input  logic [15:0] cfg_thlen,
  output logic        buf_swap,
  output logic [7:0]  Thsync,
  output logic [7:0]  Tgdel,
  output logic [15:0] Tgate,
  output logic [15:0] Thlen,
  output logic [1:0]  wr_idx,
  output logic [1:0]  rd_idx,
  output logic        rdy_valid,
  output logic        busy
`ifdef VID_SCHED_STATS_EN
  , output logic [DROP_W-1:0] drop_cnt
`endif
);

  // Too-short pulses would be missed by the receiver's synchronizer
  localparam int PW_EFF = (SWAP_PW < SWAP_PW_MIN) ? SWAP_PW_MIN : SWAP_PW;
  localparam tim_cfg_t DEF_CFG = '{DEF_THSYNC, DEF_TGDEL, DEF_TGATE, DEF_THLEN};

  logic [2:0] state;
  buf_idx_t   wr_q, rdy_q, rd_q;
  tim_cfg_t   shadow_q, pend_q;
  logic       cfg_pend;
  logic       issue;
  logic       pulse_done;

  assign issue = (state == ST_IDLE) && en && rdy_valid;

  swap_pulse_stretch #(.PW(PW_EFF)) u_pulse (
    .clk   (clk),
    .rst_n (rst_n),
    .start (issue),
    .pulse (buf_swap),
    .done  (pulse_done)
  );

  // Scheduler sequencing: issue a swap, let the pulse run out, wait for the display to finish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (issue)      state <= ST_SWAP;
        ST_SWAP: if (pulse_done) state <= ST_WAIT;
        ST_WAIT: if (disp_done)  state <= ST_IDLE;
        default:                 state <= ST_IDLE;
      endcase
    end
  end

  // Buffer rotation; a frame completing on the issue cycle goes straight to the ready slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= RST_WR_IDX;
      rdy_q     <= RST_RDY_IDX;
      rd_q      <= RST_RD_IDX;
      rdy_valid <= 1'b0;
    end else if (issue && wr_done) begin
      rd_q  <= rdy_q;
      rdy_q <= wr_q;
      wr_q  <= rd_q;
    end else if (issue) begin
      rd_q      <= rdy_q;
      rdy_q     <= rd_q;
      rdy_valid <= 1'b0;
    end else if (wr_done) begin
      wr_q      <= rdy_q;
      rdy_q     <= wr_q;
      rdy_valid <= 1'b1;
    end
  end

  // Pending timing set collects host writes; the active set only moves on a swap issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= DEF_CFG;
      pend_q   <= DEF_CFG;
      cfg_pend <= 1'b0;
    end else begin
      if (issue && cfg_pend) shadow_q <= pend_q;
      if (cfg_wr) begin
        pend_q   <= '{cfg_thsync, cfg_tgdel, cfg_tgate, cfg_thlen};
        cfg_pend <= 1'b1;
      end else if (issue) begin
        cfg_pend <= 1'b0;
      end
    end
  end

`ifdef VID_SCHED_STATS_EN
  logic drop;
  assign drop = wr_done && rdy_valid && !issue;

  // Count ready frames overwritten before display, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

  assign wr_idx = wr_q;
  assign rd_idx = rd_q;
  assign busy   = (state != ST_IDLE);
  assign Thsync = shadow_q.thsync;
  assign Tgdel  = shadow_q.tgdel;
  assign Tgate  = shadow_q.tgate;
  assign Thlen  = shadow_q.thlen;

endmodule

// File: tb/tb_vid_swap_sched.sv
// tb/tb_vid_swap_sched.sv - randomized and directed checks of vid_swap_sched against a buffer-level model
module tb_vid_swap_sched;

  localparam int SWAP_PW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, wr_done = 1'b0, disp_done = 1'b0, cfg_wr = 1'b0;
  logic [7:0]  cfg_thsync = '0, cfg_tgdel = '0;
  logic [15:0] cfg_tgate = '0, cfg_thlen = '0;
  logic        buf_swap, rdy_valid, busy;
  logic [7:0]  Thsync, Tgdel;
  logic [15:0] Tgate, Thlen;
  logic [1:0]  wr_idx, rd_idx;
`ifdef VID_SCHED_STATS_EN
  logic [15:0] drop_cnt;
`endif

  vid_swap_sched #(.SWAP_PW(SWAP_PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_done(wr_done), .disp_done(disp_done),
    .cfg_wr(cfg_wr), .cfg_thsync(cfg_thsync), .cfg_tgdel(cfg_tgdel),
    .cfg_tgate(cfg_tgate), .cfg_thlen(cfg_thlen), .buf_swap(buf_swap),
    .Thsync(Thsync), .Tgdel(Tgdel), .Tgate(Tgate), .Thlen(Thlen),
    .wr_idx(wr_idx), .rd_idx(rd_idx), .rdy_valid(rdy_valid), .busy(busy)
`ifdef VID_SCHED_STATS_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: three buffer slots, a remaining-high-time count and a waiting flag
  int m_wr, m_rdy, m_rd, m_left, m_drop;
  bit m_valid, m_wait, m_pflag;
  int m_sh [4];
  int m_pd [4];

  always @(posedge clk or negedge rst_n) begin : model
    int wr, rdy, rd, t, left, drop;
    bit valid, waiting, iss, pflag;
    int sh [4];
    int pd [4];
    if (!rst_n) begin
      m_wr <= 0; m_rdy <= 1; m_rd <= 2; m_valid <= 0; m_left <= 0; m_wait <= 0;
      m_drop <= 0; m_pflag <= 0;
      m_sh <= '{4, 2, 64, 100};
      m_pd <= '{4, 2, 64, 100};
    end else begin
      wr = m_wr; rdy = m_rdy; rd = m_rd; valid = m_valid; left = m_left;
      waiting = m_wait; drop = m_drop; sh = m_sh; pd = m_pd; pflag = m_pflag;
      iss = en && valid && left == 0 && !waiting;
      if (waiting && disp_done) waiting = 0;
      if (left > 0) begin
        left--;
        if (left == 0) waiting = 1;
      end
      if (iss) begin
        if (wr_done) begin t = rd; rd = rdy; rdy = wr; wr = t; end
        else begin t = rd; rd = rdy; rdy = t; valid = 0; end
        left = SWAP_PW;
        if (pflag) sh = pd;
      end else if (wr_done) begin
        if (valid && drop < 65535) drop++;
        t = wr; wr = rdy; rdy = t; valid = 1;
      end
      if (cfg_wr) begin
        pd = '{int'(cfg_thsync), int'(cfg_tgdel), int'(cfg_tgate), int'(cfg_thlen)};
        pflag = 1;
      end else if (iss) begin
        pflag = 0;
      end
      m_wr <= wr; m_rdy <= rdy; m_rd <= rd; m_valid <= valid; m_left <= left;
      m_wait <= waiting; m_drop <= drop; m_sh <= sh; m_pd <= pd; m_pflag <= pflag;
    end
  end

  // Per-cycle comparison on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("buf_swap",  buf_swap,  (m_left > 0) ? 1 : 0);
      check("busy",      busy,      (m_left > 0 || m_wait) ? 1 : 0);
      check("wr_idx",    wr_idx,    m_wr);
      check("rd_idx",    rd_idx,    m_rd);
      check("rdy_valid", rdy_valid, m_valid);
      check("Thsync",    Thsync,    m_sh[0]);
      check("Tgdel",     Tgdel,     m_sh[1]);
      check("Tgate",     Tgate,     m_sh[2]);
      check("Thlen",     Thlen,     m_sh[3]);
      check("perm",      (wr_idx != rd_idx && wr_idx != 2'd3 && rd_idx != 2'd3) ? 1 : 0, 1);
`ifdef VID_SCHED_STATS_EN
      check("drop_cnt",  drop_cnt,  m_drop);
`endif
    end
  end

  task automatic step(input bit e, input bit w, input bit d, input bit c);
    en = e; wr_done = w; disp_done = d; cfg_wr = c;
    @(posedge clk);
    #1;
    wr_done = 1'b0; disp_done = 1'b0; cfg_wr = 1'b0;
  endtask

  int highs;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_wr", wr_idx, 0);
    check("rst_rd", rd_idx, 2);
    check("rst_valid", rdy_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_swap", buf_swap, 0);
    check("rst_thsync", Thsync, 4);
    check("rst_thlen", Thlen, 100);

    // Frame completes, then swap issues the following cycle
    repeat (9) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("t1_wr", wr_idx, 1);
    check("t1_valid", rdy_valid, 1);
    check("t1_noswap", buf_swap, 0);
    step(1, 0, 0, 0);
    check("t1_swap", buf_swap, 1);
    check("t1_rd", rd_idx, 0);
    check("t1_wr2", wr_idx, 1);
    highs = 1;
    repeat (6) begin
      step(1, 0, 0, 0);
      highs += buf_swap;
    end
    check("t1_pulse_len", highs, 4);

    // Three frames completing while waiting on display
    repeat (3) step(1, 1, 0, 0);
`ifdef VID_SCHED_STATS_EN
    check("t2_drop", drop_cnt, 2);
`endif
    check("t2_wr", wr_idx, 2);
    check("t2_rd", rd_idx, 0);
    step(0, 0, 1, 0);
    check("t2_idle", busy, 0);

    // Two config writes before the swap: last one wins, shadow holds until issue
    cfg_thsync = 8'd6; cfg_tgdel = 8'd1; cfg_tgate = 16'd10; cfg_thlen = 16'd20;
    step(0, 0, 0, 1);
    cfg_thsync = 8'd9; cfg_tgdel = 8'd3; cfg_tgate = 16'd70; cfg_thlen = 16'd120;
    step(0, 0, 0, 1);
    check("t4_hold", Thsync, 4);

    // Enable held low with a frame ready
    highs = 0;
    repeat (100) begin
      step(0, 0, 0, 0);
      highs += buf_swap;
    end
    check("t5_noswap", highs, 0);

    // Enable and frame completion in the same cycle as the issue
    step(1, 1, 0, 0);
    check("t3_swap", buf_swap, 1);
    check("t3_rd", rd_idx, 1);
    check("t3_wr", wr_idx, 0);
    check("t3_valid", rdy_valid, 1);
    check("t4_thsync", Thsync, 9);
    check("t4_tgate", Tgate, 70);
`ifdef VID_SCHED_STATS_EN
    check("t3_drop", drop_cnt, 2);
`endif

    // Reset in the middle of the pulse
    step(1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("t6_swap", buf_swap, 0);
    check("t6_wr", wr_idx, 0);
    check("t6_rd", rd_idx, 2);
    check("t6_valid", rdy_valid, 0);
    check("t6_thsync", Thsync, 4);
    check("t6_tgate", Tgate, 64);
    check("t6_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic, checked each cycle by the model
    for (int i = 0; i < 4000; i++) begin
      cfg_thsync = 8'($urandom);
      cfg_tgdel  = 8'($urandom);
      cfg_tgate  = 16'($urandom);
      cfg_thlen  = 16'($urandom);
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
